// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_seq
// Brief    : Parametrised tail-light sequencer with turn sweep, hazard flash
//            and brake overlay; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module tail_light_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lt,
    input  logic             rt,
    input  logic             haz,
    input  logic             brk,
    output logic [LAMPS-1:0] li,
    output logic [LAMPS-1:0] ri,
    output logic [1:0]       mode
);

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PHW = $clog2(LAMPS + 1);

    localparam logic [PW-1:0]    c_TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    c_PRE_ONE   = PW'(1);
    localparam logic [PHW-1:0]   c_PH_LAST   = PHW'(LAMPS);
    localparam logic [PHW-1:0]   c_PH_ONE    = PHW'(1);
    localparam logic [PHW-1:0]   c_PH_ZERO   = '0;
    localparam logic [LAMPS-1:0] c_ALL_ON    = '1;
    localparam logic [LAMPS-1:0] c_ALL_OFF   = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2,
        S_HAZ   = 2'd3
    } mode_t;

    mode_t            r_mode;
    logic [PHW-1:0]   r_phase;
    logic [PW-1:0]    r_pre;
    logic [LAMPS-1:0] r_li;
    logic [LAMPS-1:0] r_ri;

    mode_t            w_req;
    mode_t            w_mode_nxt;
    logic [PHW-1:0]   w_phase_nxt;
    logic [PW-1:0]    w_pre_nxt;
    logic [LAMPS-1:0] w_li_nxt;
    logic [LAMPS-1:0] w_ri_nxt;
    logic [LAMPS-1:0] w_sweep;
    logic [LAMPS-1:0] w_brake;
    logic             w_tick;

    // Lamps below the phase index are lit: (1<<phase)-1 without a wide shift.
    function automatic logic [LAMPS-1:0] therm(input logic [PHW-1:0] p);
        logic [LAMPS-1:0] v;
        v = '0;
        for (int i = 0; i < LAMPS; i++) begin
            v[i] = (PHW'(i) < p);
        end
        return v;
    endfunction

    always_comb begin
        w_req = S_IDLE;
        if (haz || (lt && rt)) begin
            w_req = S_HAZ;
        end else if (lt) begin
            w_req = S_LEFT;
        end else if (rt) begin
            w_req = S_RIGHT;
        end
    end

    assign w_tick = (r_pre == c_TICK_LAST);

    always_comb begin
        w_mode_nxt  = r_mode;
        w_phase_nxt = r_phase;
        w_pre_nxt   = r_pre;
        if (w_req != r_mode) begin
            w_mode_nxt  = w_req;
            w_phase_nxt = c_PH_ZERO;
            w_pre_nxt   = '0;
        end else begin
            w_pre_nxt = w_tick ? '0 : (r_pre + c_PRE_ONE);
            if (w_tick) begin
                case (r_mode)
                    S_LEFT, S_RIGHT: w_phase_nxt = (r_phase == c_PH_LAST) ? c_PH_ZERO
                                                                         : (r_phase + c_PH_ONE);
                    S_HAZ:           w_phase_nxt = (r_phase == c_PH_ZERO) ? c_PH_ONE : c_PH_ZERO;
                    default:         w_phase_nxt = c_PH_ZERO;
                endcase
            end
        end
    end

    // Lamp pattern is decoded from the next state so it lands with it.
    assign w_sweep = therm(w_phase_nxt);
    assign w_brake = brk ? c_ALL_ON : c_ALL_OFF;

    always_comb begin
        w_li_nxt = w_brake;
        w_ri_nxt = w_brake;
        case (w_mode_nxt)
            S_LEFT: begin
                w_li_nxt = w_sweep;
            end
            S_RIGHT: begin
                w_ri_nxt = w_sweep;
            end
            S_HAZ: begin
                w_li_nxt = (w_phase_nxt == c_PH_ONE) ? c_ALL_ON : c_ALL_OFF;
                w_ri_nxt = (w_phase_nxt == c_PH_ONE) ? c_ALL_ON : c_ALL_OFF;
            end
            default: begin
                w_li_nxt = w_brake;
                w_ri_nxt = w_brake;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= S_IDLE;
            r_phase <= '0;
            r_pre   <= '0;
            r_li    <= '0;
            r_ri    <= '0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_phase <= w_phase_nxt;
            r_pre   <= w_pre_nxt;
            r_li    <= w_li_nxt;
            r_ri    <= w_ri_nxt;
        end
    end

    assign li   = r_li;
    assign ri   = r_ri;
    assign mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tail_light_seq
// Brief    : Scoreboard bench for tail_light_seq (3-lamp/div-1 and 4-lamp/div-4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tail_light_seq;

    logic       clk;
    logic       rst;
    logic       lt;
    logic       rt;
    logic       haz;
    logic       brk;
    logic [2:0] a_li;
    logic [2:0] a_ri;
    logic [1:0] a_mode;
    logic [3:0] b_li;
    logic [3:0] b_ri;
    logic [1:0] b_mode;

    typedef struct {
        bit         sel;
        logic [1:0] m;
        logic [3:0] l;
        logic [3:0] r;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   errors;
    int   checks;

    tail_light_seq #(.LAMPS(3), .TICK_DIV(1)) u_a (
        .clk(clk), .rst(rst), .lt(lt), .rt(rt), .haz(haz), .brk(brk),
        .li(a_li), .ri(a_ri), .mode(a_mode)
    );

    tail_light_seq #(.LAMPS(4), .TICK_DIV(4)) u_b (
        .clk(clk), .rst(rst), .lt(lt), .rt(rt), .haz(haz), .brk(brk),
        .li(b_li), .ri(b_ri), .mode(b_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per edge, sampled 1 time unit after it.
    initial begin
        exp_t       e;
        logic [9:0] act;
        logic [9:0] req;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = e.sel ? {b_mode, b_li, b_ri} : {a_mode, 1'b0, a_li, 1'b0, a_ri};
                req = {e.m, e.l, e.r};
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL %s: got mode=%0d li=%b ri=%b, want mode=%0d li=%b ri=%b",
                             e.nm, act[9:8], act[7:4], act[3:0], e.m, e.l, e.r);
                end
            end
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input logic s_rst, input logic s_lt, input logic s_rt,
                        input logic s_haz, input logic s_brk, input bit sel,
                        input logic [1:0] m, input logic [3:0] l, input logic [3:0] r,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        rst = s_rst; lt = s_lt; rt = s_rt; haz = s_haz; brk = s_brk;
        e.sel = sel; e.m = m; e.l = l; e.r = r; e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        logic [3:0] ramp [5];
        int         wait_cnt;
        errors = 0;
        checks = 0;
        rst = 1'b1; lt = 1'b0; rt = 1'b0; haz = 1'b0; brk = 1'b0;
        ramp[0] = 4'b0000; ramp[1] = 4'b0001; ramp[2] = 4'b0011;
        ramp[3] = 4'b0111; ramp[4] = 4'b1111;

        // Reset dominates all requests
        step(1, 1, 1, 1, 1, 0, 2'd0, 4'b000, 4'b000, "reset_hold0");
        step(1, 1, 1, 1, 1, 0, 2'd0, 4'b000, 4'b000, "reset_hold1");
        step(1, 1, 1, 1, 1, 1, 2'd0, 4'b0000, 4'b0000, "reset_hold_b");

        // Idle brake overlay
        step(0, 0, 0, 0, 1, 0, 2'd0, 4'b111, 4'b111, "idle_brake");

        // Left sweep, 4-step period plus restart
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b000, 4'b000, "left_p0");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b001, 4'b000, "left_p1");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b011, 4'b000, "left_p2");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b111, 4'b000, "left_p3");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b000, 4'b000, "left_wrap");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b001, 4'b000, "left_again1");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b011, 4'b000, "left_again2");

        // Hazard preempts mid-sweep; brake ignored
        step(0, 1, 0, 1, 0, 0, 2'd3, 4'b000, 4'b000, "haz_enter");
        step(0, 1, 0, 1, 1, 0, 2'd3, 4'b111, 4'b111, "haz_on_brk");
        step(0, 1, 0, 1, 1, 0, 2'd3, 4'b000, 4'b000, "haz_off_brk");
        step(0, 1, 0, 1, 0, 0, 2'd3, 4'b111, 4'b111, "haz_on");

        // lt+rt is hazard, same mode so flash continues
        step(0, 1, 1, 0, 0, 0, 2'd3, 4'b000, 4'b000, "ltrt_off");
        step(0, 1, 1, 0, 0, 0, 2'd3, 4'b111, 4'b111, "ltrt_on");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b000, 4'b000, "rt_release");
        step(0, 1, 0, 0, 0, 0, 2'd1, 4'b001, 4'b000, "rt_release_p1");

        // Brake during sweep does not restart it
        step(0, 1, 0, 0, 1, 0, 2'd1, 4'b011, 4'b111, "left_brk");

        // Dropping lt mid-sweep goes straight to idle
        step(0, 0, 0, 0, 0, 0, 2'd0, 4'b000, 4'b000, "left_drop");

        // Right sweep
        step(0, 0, 1, 0, 0, 0, 2'd2, 4'b000, 4'b000, "right_p0");
        step(0, 0, 1, 0, 0, 0, 2'd2, 4'b000, 4'b001, "right_p1");
        step(0, 0, 1, 0, 1, 0, 2'd2, 4'b111, 4'b011, "right_p2_brk");

        // Reset in the middle of a hazard flash
        step(0, 0, 0, 1, 0, 0, 2'd3, 4'b000, 4'b000, "haz2_enter");
        step(0, 0, 0, 1, 0, 0, 2'd3, 4'b111, 4'b111, "haz2_on");
        step(1, 0, 0, 1, 0, 0, 2'd0, 4'b000, 4'b000, "rst_mid0");
        step(1, 0, 0, 1, 0, 0, 2'd0, 4'b000, 4'b000, "rst_mid1");
        step(0, 0, 0, 0, 0, 0, 2'd0, 4'b000, 4'b000, "rst_release0");
        step(0, 0, 0, 0, 0, 0, 2'd0, 4'b000, 4'b000, "rst_release1");

        // Prescaled right sweep with brake on the 4-lamp, divide-by-4 instance
        step(0, 0, 0, 0, 0, 1, 2'd0, 4'b0000, 4'b0000, "b_idle");
        for (int k = 0; k < 24; k++) begin
            step(0, 0, 1, 0, 1, 1, 2'd2, 4'b1111, ramp[(k / 4) % 5],
                 $sformatf("b_right_k%0d", k));
        end

        step(0, 0, 0, 0, 0, 1, 2'd0, 4'b0000, 4'b0000, "b_drop");

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
Parametrised sequential tail-light controller, the next generation of the fixed 3-lamp controller. Drives LAMPS lamps per side with a left/right thermometer sweep, a hazard flash, and a brake overlay. The step rate is set by a built-in prescaler. Sits between the driver-input debouncing logic and the lamp drivers; all outputs are registered.

Parameters:
LAMPS, 3, lamps per side; legal range 1..16
TICK_DIV, 1, clock cycles per sequence step; legal range >= 1

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
lt  input  1  left-turn request, level
rt  input  1  right-turn request, level
haz  input  1  hazard request, level
brk  input  1  brake request, level
li  output  LAMPS  left lamps; bit 0 is innermost
ri  output  LAMPS  right lamps; bit 0 is innermost
mode  output  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: mode=IDLE, phase=0, prescaler=0, li=0, ri=0, all registered.
  - rst dominates every other input, including mid-sequence.
  - The first edge with rst=0 evaluates inputs normally.
- Requested mode, evaluated every edge in priority order:
  - haz=1 or (lt=1 and rt=1): HAZ
  - else lt=1: LEFT
  - else rt=1: RIGHT
  - else: IDLE
- State:
  - prescaler: width max(1, clog2(TICK_DIV)).
  - phase: width clog2(LAMPS+1).
  - tick is true when prescaler == TICK_DIV-1.
- Mode change, when requested != current mode at an edge:
  - mode takes the requested value; phase=0 and prescaler=0 at that edge.
  - The new mode is visible on the outputs after that same edge (1-cycle input-to-output latency).
- Same mode:
  - prescaler increments and wraps to 0 on tick.
  - On tick, phase advances:
    - LEFT/RIGHT: 0,1,...,LAMPS, then wraps to 0.
    - HAZ: toggles between 0 and 1.
    - IDLE: phase held at 0.
- Output decode, registered from next state:
  - LEFT: li = (1<<phase)-1 (phase 0 all off, phase LAMPS all on); ri = brk ? all-ones : 0.
  - RIGHT: mirror of LEFT.
  - HAZ: li = ri = (phase==1) ? all-ones : 0. brk is ignored.
  - IDLE: li = ri = brk ? all-ones : 0.
- Cycle lengths:
  - LEFT/RIGHT: (LAMPS+1)*TICK_DIV cycles.
  - HAZ: 2*TICK_DIV cycles.
- brk changes do not reset phase or prescaler. They affect outputs 1 cycle later.
- Dropping the turn input mid-sweep goes to IDLE on the next edge; no sweep completion.
- TICK_DIV=1: the prescaler is constant 0 and tick is always true.
- No combinational path from inputs to outputs.

Test Plan:
- Reset hold: LAMPS=3, TICK_DIV=1, rst=1 for 3 cycles with lt=rt=haz=brk=1 -> li=000, ri=000, mode=0 throughout.
- Left sweep: LAMPS=3, TICK_DIV=1, lt=1 sampled at edge N -> after edges N..N+4: li=000,001,011,111,000; ri=000; mode=1.
- Prescaled right sweep with brake: LAMPS=4, TICK_DIV=4, rt=1 and brk=1 -> ri holds each of 0000,0001,0011,0111,1111 for 4 cycles (20-cycle period); li=1111 throughout.
- Hazard priority: TICK_DIV=1, lt=1 mid-sweep (li=011), then haz=1 -> next edge mode=3, li=ri=000. Then li=ri alternate 111/000 every cycle; brk=1 changes nothing.
- lt and rt together: lt=rt=1, haz=0 -> mode=3, same flash as HAZ. Releasing rt -> next edge mode=1, li=000, sweep restarts.
- Reset mid-operation: haz flashing, rst=1 for 2 cycles -> li=ri=000, mode=0 after the first rst edge. Release with haz=0, brk=0 -> outputs remain 000.
